// File: rtl/chacha20_pld_xor_pkg.sv
// chacha20_pld_xor_pkg: shared widths, FSM states and byte helpers
package chacha20_pld_xor_pkg;
  localparam int BEAT_W = 128;
  localparam int KEEP_W = BEAT_W / 8;
  localparam int KS_W = 512;
  localparam int SLICES = KS_W / BEAT_W;
  typedef enum logic [2:0] {IDLE, KS_REQ, KS_WAIT, XFER, LEN, FIN} state_t;
  function automatic logic [63:0] popcount(input logic [KEEP_W-1:0] k);
    popcount = '0;
    for (int i = 0; i < KEEP_W; i++) popcount = popcount + 64'(k[i]);
  endfunction
  function automatic logic [BEAT_W-1:0] byte_mask(input logic [KEEP_W-1:0] k);
    byte_mask = '0;
    for (int i = 0; i < KEEP_W; i++) byte_mask[8*i +: 8] = {8{k[i]}};
  endfunction
endpackage

// File: rtl/chacha20_beat_reg.sv
// chacha20_beat_reg: output slot shared by the user port and the MAC port
module chacha20_beat_reg
  import chacha20_pld_xor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BEAT_W-1:0] out_d,
  input  logic [KEEP_W-1:0] out_k,
  input  logic              out_l,
  input  logic [BEAT_W-1:0] pld_d,
  input  logic [KEEP_W-1:0] pld_k,
  input  logic              out_ready,
  input  logic              pld_ready,
  output logic              out_valid,
  output logic [BEAT_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  output logic              pld_valid,
  output logic [BEAT_W-1:0] pld_data,
  output logic [KEEP_W-1:0] pld_keep,
  output logic              free,
  output logic              empty
);
  assign free = (!out_valid || out_ready) && (!pld_valid || pld_ready);
  assign empty = !out_valid && !pld_valid;
  // load both consumers together; each valid drops on its own handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      pld_valid <= 1'b0;
      out_data <= '0;
      out_keep <= '0;
      out_last <= 1'b0;
      pld_data <= '0;
      pld_keep <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      pld_valid <= 1'b1;
      out_data <= out_d;
      out_keep <= out_k;
      out_last <= out_l;
      pld_data <= pld_d;
      pld_keep <= pld_k;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (pld_ready) pld_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/chacha20_pld_xor.sv
// chacha20_pld_xor: XORs payload beats with ChaCha20 keystream and feeds the MAC
module chacha20_pld_xor
  import chacha20_pld_xor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic              pld_empty,
  input  logic [63:0]       aad_len_bytes,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic              in_last,
  output logic              ks_req,
  input  logic              ks_valid,
  input  logic [KS_W-1:0]   ks_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic [KEEP_W-1:0] out_keep,
  output logic              out_last,
  output logic              pld_valid,
  input  logic              pld_ready,
  output logic [BEAT_W-1:0] pld_data,
  output logic [KEEP_W-1:0] pld_keep,
  output logic              len_valid,
  input  logic              len_ready,
  output logic [127:0]      len_block,
  output logic              busy,
  output logic              done
);
  state_t state, nxt;
  logic [KS_W-1:0] ks_buf;
  logic [1:0] idx;
  logic [63:0] pld_len, aad_r;
  logic dir_r, last_acc, free, empty, accept;
  logic [BEAT_W-1:0] mask, xr, pr;
  assign accept = in_valid && in_ready;
  assign in_ready = (state == XFER) && free && !last_acc;
  assign mask = byte_mask(in_keep);
  assign xr = (in_data ^ ks_buf[BEAT_W*idx +: BEAT_W]) & mask;
  assign pr = dir_r ? (in_data & mask) : xr;
  assign ks_req = state == KS_REQ;
  assign len_valid = state == LEN;
  assign done = state == FIN;
  assign busy = state != IDLE;
  assign len_block = {pld_len, aad_r};
  chacha20_beat_reg u_slot (
    .clk(clk), .rst(rst), .load(accept),
    .out_d(xr), .out_k(in_keep), .out_l(in_last),
    .pld_d(pr), .pld_k(in_keep),
    .out_ready(out_ready), .pld_ready(pld_ready),
    .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .pld_valid(pld_valid), .pld_data(pld_data), .pld_keep(pld_keep),
    .free(free), .empty(empty)
  );
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // next state; a last beat waits for the slot to drain before the length block
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? (pld_empty ? LEN : KS_REQ) : IDLE;
      KS_REQ:  nxt = KS_WAIT;
      KS_WAIT: nxt = ks_valid ? XFER : KS_WAIT;
      XFER:    nxt = (last_acc && empty) ? LEN :
                     (accept && !in_last && idx == 2'(SLICES - 1)) ? KS_REQ : XFER;
      LEN:     nxt = len_ready ? FIN : LEN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // message context, keystream buffer, slice index and payload byte count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_buf <= '0;
      idx <= '0;
      pld_len <= '0;
      aad_r <= '0;
      dir_r <= 1'b0;
      last_acc <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        pld_len <= '0;
        aad_r <= aad_len_bytes;
        dir_r <= dir;
        last_acc <= 1'b0;
        idx <= '0;
      end
      if (state == KS_WAIT && ks_valid) begin
        ks_buf <= ks_data;
        idx <= '0;
      end
      if (accept) begin
        pld_len <= pld_len + popcount(in_keep);
        idx <= idx + 2'd1;
        last_acc <= in_last;
      end
    end
  end
endmodule

// File: tb/tb_chacha20_pld_xor.sv
// tb_chacha20_pld_xor: directed messages checked against a keystream byte-stream model
module tb_chacha20_pld_xor;
  logic clk = 0, rst = 1, start = 0, dir = 0, pld_empty = 0;
  logic [63:0] aad_len_bytes = '0;
  logic in_valid = 0, in_ready, in_last = 0;
  logic [127:0] in_data = '0;
  logic [15:0] in_keep = '0;
  logic ks_req, ks_valid;
  logic [511:0] ks_data;
  logic out_valid, out_ready = 1, out_last;
  logic [127:0] out_data;
  logic [15:0] out_keep;
  logic pld_valid, pld_ready = 1;
  logic [127:0] pld_data;
  logic [15:0] pld_keep;
  logic len_valid, len_ready = 1;
  logic [127:0] len_block;
  logic busy, done;

  chacha20_pld_xor dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .pld_empty(pld_empty),
    .aad_len_bytes(aad_len_bytes), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .ks_req(ks_req),
    .ks_valid(ks_valid), .ks_data(ks_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last), .pld_valid(pld_valid),
    .pld_ready(pld_ready), .pld_data(pld_data), .pld_keep(pld_keep), .len_valid(len_valid),
    .len_ready(len_ready), .len_block(len_block), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [511:0] ks_blk [8];
  logic [127:0] msg_d [16];
  logic [15:0] msg_k [16];
  logic [127:0] pt [5], ct [5], ct_pld [5];
  logic [127:0] od_q[$], pd_q[$], len_q[$];
  logic [15:0] ok_q[$], pk_q[$];
  logic ol_q[$];
  int done_total = 0, ks_total = 0, ks_base = 0;
  int ob, pb, lb, db, kb;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // keystream as a flat byte stream: byte j of a message is byte j%64 of block j/64
  function automatic logic [7:0] ks_byte(input int j);
    logic [511:0] b;
    b = ks_blk[(j / 64) % 8];
    return b[8*(j % 64) +: 8];
  endfunction

  function automatic logic [127:0] model_xor(input logic [127:0] d, input logic [15:0] k, input int beat);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = k[b] ? d[8*b +: 8] ^ ks_byte(16*beat + b) : 8'h00;
    return r;
  endfunction

  function automatic logic [127:0] model_keep(input logic [127:0] d, input logic [15:0] k);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = k[b] ? d[8*b +: 8] : 8'h00;
    return r;
  endfunction

  // ChaCha core stand-in: answers each request one cycle later with the next block
  initial begin
    logic [511:0] blk;
    ks_valid = 0;
    ks_data = '0;
    forever begin
      @(negedge clk);
      if (ks_req) begin
        ks_total++;
        blk = ks_blk[(ks_total - 1 - ks_base) % 8];
        @(posedge clk); #1;
        ks_valid = 1;
        ks_data = blk;
        @(posedge clk); #1;
        ks_valid = 0;
      end
    end
  end

  // record every beat that completes a handshake on each port
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      od_q.push_back(out_data);
      ok_q.push_back(out_keep);
      ol_q.push_back(out_last);
    end
    if (pld_valid && pld_ready) begin
      pd_q.push_back(pld_data);
      pk_q.push_back(pld_keep);
    end
    if (len_valid && len_ready) len_q.push_back(len_block);
    if (done) done_total++;
  end

  task automatic snap();
    ob = od_q.size();
    pb = pd_q.size();
    lb = len_q.size();
    db = done_total;
    kb = ks_total;
    ks_base = ks_total;
  endtask

  task automatic do_start(input logic d, input logic e, input logic [63:0] aad);
    @(posedge clk); #1;
    dir = d;
    pld_empty = e;
    aad_len_bytes = aad;
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l);
    bit ok;
    ok = 0;
    in_valid = 1;
    in_data = d;
    in_keep = k;
    in_last = l;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    chk("in_accept", 128'(ok), 128'd1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk("done_timeout", 128'(ok), 128'd1);
  endtask

  task automatic run_msg(input int n, input logic d, input logic [63:0] aad);
    snap();
    do_start(d, n == 0, aad);
    for (int i = 0; i < n; i++) send_beat(msg_d[i], msg_k[i], i == n - 1);
    wait_done();
  endtask

  task automatic check_msg(input int n, input logic d, input logic [63:0] aad);
    logic [63:0] plen;
    logic [127:0] e;
    plen = 0;
    chk("out_count", 128'(od_q.size() - ob), 128'(n));
    chk("pld_count", 128'(pd_q.size() - pb), 128'(n));
    for (int i = 0; i < n; i++) begin
      e = model_xor(msg_d[i], msg_k[i], i);
      chk($sformatf("out_data[%0d]", i), od_q[ob + i], e);
      chk($sformatf("out_keep[%0d]", i), 128'(ok_q[ob + i]), 128'(msg_k[i]));
      chk($sformatf("out_last[%0d]", i), 128'(ol_q[ob + i]), 128'(i == n - 1));
      chk($sformatf("pld_data[%0d]", i), pd_q[pb + i], d ? model_keep(msg_d[i], msg_k[i]) : e);
      chk($sformatf("pld_keep[%0d]", i), 128'(pk_q[pb + i]), 128'(msg_k[i]));
      plen += 64'($countones(msg_k[i]));
    end
    chk("len_count", 128'(len_q.size() - lb), 128'd1);
    chk("len_block", len_q[lb], {plen, aad});
    chk("done_pulses", 128'(done_total - db), 128'd1);
    chk("ks_requests", 128'(ks_total - kb), 128'((n + 3) / 4));
  endtask

  initial begin
    logic [63:0] aad;
    for (int i = 0; i < 8; i++)
      ks_blk[i] = {16{$urandom()}};
    for (int i = 0; i < 8; i++)
      for (int w = 0; w < 16; w++) ks_blk[i][32*w +: 32] = $urandom();
    #1;
    chk("reset_ctrl", 128'({out_valid, pld_valid, len_valid, ks_req, done, busy, in_ready}), 128'd0);
    chk("reset_data", out_data | pld_data | len_block, 128'd0);
    @(posedge clk); #1;
    rst = 0;

    aad = {$urandom(), $urandom()};
    for (int i = 0; i < 5; i++) begin
      pt[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      msg_d[i] = pt[i];
      msg_k[i] = 16'hFFFF;
    end
    run_msg(5, 0, aad);
    check_msg(5, 0, aad);
    chk("enc_beat4_blk1", od_q[ob + 4], pt[4] ^ ks_blk[1][127:0]);
    chk("enc_len80", len_q[lb], {64'd80, aad});
    for (int i = 0; i < 5; i++) begin
      ct[i] = od_q[ob + i];
      ct_pld[i] = pd_q[pb + i];
      msg_d[i] = ct[i];
    end

    run_msg(5, 1, aad);
    check_msg(5, 1, aad);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("dec_plain[%0d]", i), od_q[ob + i], pt[i]);
      chk($sformatf("dec_mac_same[%0d]", i), pd_q[pb + i], ct_pld[i]);
    end

    for (int i = 0; i < 8; i++)
      for (int w = 0; w < 16; w++) ks_blk[i][32*w +: 32] = $urandom();
    aad = 64'($urandom_range(0, 999));
    for (int i = 0; i < 3; i++) begin
      msg_d[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      msg_k[i] = (i == 2) ? 16'h001F : 16'hFFFF;
    end
    run_msg(3, 0, aad);
    check_msg(3, 0, aad);
    chk("partial_zero_hi", 128'(od_q[ob + 2][127:40]), 128'd0);
    chk("partial_len", 128'(len_q[lb][127:64]), 128'd37);

    len_ready = 0;
    snap();
    do_start(0, 1, 64'd13);
    repeat (3) @(negedge clk);
    chk("len_hold", 128'(len_valid), 128'd1);
    @(posedge clk); #1;
    len_ready = 1;
    wait_done();
    check_msg(0, 0, 64'd13);
    chk("empty_len13", len_q[lb], 128'h0000000000000000_000000000000000D);

    for (int i = 0; i < 3; i++) begin
      msg_d[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      msg_k[i] = 16'hFFFF;
    end
    pld_ready = 0;
    fork
      run_msg(3, 0, 64'd7);
      begin
        bit seen;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          if (out_valid) begin
            seen = 1;
            break;
          end
        end
        chk("bp_first_out", 128'(seen), 128'd1);
        for (int c = 0; c < 7; c++) begin
          @(negedge clk);
          chk($sformatf("bp_in_ready[%0d]", c), 128'({in_ready, pld_valid, out_valid}), 128'b010);
        end
        @(posedge clk); #1;
        pld_ready = 1;
      end
    join
    check_msg(3, 0, 64'd7);

    for (int i = 0; i < 4; i++) begin
      msg_d[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      msg_k[i] = 16'hFFFF;
    end
    snap();
    do_start(0, 0, 64'd5);
    send_beat(msg_d[0], msg_k[0], 0);
    send_beat(msg_d[1], msg_k[1], 0);
    rst = 1;
    #1;
    chk("abort_ctrl", 128'({out_valid, pld_valid, len_valid, ks_req, done, busy, in_ready}), 128'd0);
    chk("abort_data", out_data | pld_data | len_block, 128'd0);
    @(posedge clk); #1;
    rst = 0;
    chk("abort_no_done", 128'(done_total - db), 128'd0);
    msg_d[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_msg(1, 0, 64'd21);
    check_msg(1, 0, 64'd21);
    chk("after_abort_len", 128'(len_q[lb][127:64]), 128'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
